// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the decode/write-back slice:
// instruction codes, register specifiers and processor status codes.
package y86_pkg;

   localparam int DATA_W = 64;
   localparam int NREGS  = 15;

   typedef enum logic [3:0] {
      HALT   = 4'h0,
      NOP    = 4'h1,
      CMOVXX = 4'h2,
      IRMOVQ = 4'h3,
      RMMOVQ = 4'h4,
      MRMOVQ = 4'h5,
      OPQ    = 4'h6,
      JXX    = 4'h7,
      CALL   = 4'h8,
      RET    = 4'h9,
      PUSHQ  = 4'hA,
      POPQ   = 4'hB
   } icode_t;

   typedef enum logic [2:0] {
      AOK = 3'd1,
      HLT = 3'd2,
      ADR = 3'd3,
      INS = 3'd4
   } stat_t;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

endpackage

// File: rtl/decode_writeback_if.sv
// Bundle between the fetch/execute/memory side and the decode/write-back
// stage: instruction fields and results in, operands and status out.
interface decode_writeback_if #(
   parameter int CNT_W = 32
);
   logic [3:0]       icode;
   logic [3:0]       ifun;
   logic [3:0]       rA;
   logic [3:0]       rB;
   logic             cnd;
   logic [63:0]      valE;
   logic [63:0]      valM;
   logic             imem_error;
   logic             instr_valid;
   logic             dmem_error;
   logic [63:0]      valA;
   logic [63:0]      valB;
   logic [2:0]       stat;
   logic             halted;
   logic [CNT_W-1:0] retired;

   modport master (
      output icode, ifun, rA, rB, cnd, valE, valM,
             imem_error, instr_valid, dmem_error,
      input  valA, valB, stat, halted, retired
   );

   modport slave (
      input  icode, ifun, rA, rB, cnd, valE, valM,
             imem_error, instr_valid, dmem_error,
      output valA, valB, stat, halted, retired
   );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y86-64 register file: two combinational read ports and two
// clocked write ports (E and M); M overrides E when both target one register.
module y86_regfile
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_RESET = 64'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   input  logic        we_e,
   input  logic [3:0]  dst_e,
   input  logic [63:0] wdata_e,
   input  logic        we_m,
   input  logic [3:0]  dst_m,
   input  logic [63:0] wdata_m
);

   logic [63:0] regs [0:NREGS-1];

   // Specifier 4'hF has no storage: reads return zero, writes are dropped.
   assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
   assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= (i == int'(RRSP)) ? RSP_RESET : '0;
         end
      end else begin
         if (we_e && (dst_e != RNONE)) begin
            regs[dst_e] <= wdata_e;
         end
         // Issued last so that popq %rsp leaves the loaded value in %rsp.
         if (we_m && (dst_m != RNONE)) begin
            regs[dst_m] <= wdata_m;
         end
      end
   end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode + write-back: source/destination decode, register file,
// sticky processor status and retired-instruction counter.
module decode_writeback
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_RESET = 64'd1000,
   parameter int          CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   decode_writeback_if.slave bus
);

   icode_t           icode;
   logic [3:0]       src_a;
   logic [3:0]       src_b;
   logic [3:0]       dst_e;
   logic [3:0]       dst_m;
   stat_t            stat_q;
   stat_t            stat_d;
   logic             commit;
   logic [CNT_W-1:0] retired_q;
   logic             unused_ifun;

   assign icode       = icode_t'(bus.icode);
   assign unused_ifun = ^bus.ifun;

   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode)
         CMOVXX: begin
            src_a = bus.rA;
            if (bus.cnd) dst_e = bus.rB;
         end
         IRMOVQ: begin
            dst_e = bus.rB;
         end
         RMMOVQ: begin
            src_a = bus.rA;
            src_b = bus.rB;
         end
         MRMOVQ: begin
            src_b = bus.rB;
            dst_m = bus.rA;
         end
         OPQ: begin
            src_a = bus.rA;
            src_b = bus.rB;
            dst_e = bus.rB;
         end
         CALL: begin
            src_b = RRSP;
            dst_e = RRSP;
         end
         RET: begin
            src_a = RRSP;
            src_b = RRSP;
            dst_e = RRSP;
         end
         PUSHQ: begin
            src_a = bus.rA;
            src_b = RRSP;
            dst_e = RRSP;
         end
         POPQ: begin
            src_a = RRSP;
            src_b = RRSP;
            dst_e = RRSP;
            dst_m = bus.rA;
         end
         default: begin
         end
      endcase
   end

   // Fault checks follow pipeline order: fetch, decode legality, memory, halt.
   always_comb begin
      stat_d = stat_q;
      commit = 1'b0;
      if (stat_q == AOK) begin
         if (bus.imem_error) begin
            stat_d = ADR;
         end else if (!bus.instr_valid) begin
            stat_d = INS;
         end else if (bus.dmem_error) begin
            stat_d = ADR;
         end else if (icode == HALT) begin
            stat_d = HLT;
         end else begin
            commit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= AOK;
      end else begin
         stat_q <= stat_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_q <= '0;
      end else if (commit) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   y86_regfile #(
      .RSP_RESET (RSP_RESET)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .src_a   (src_a),
      .src_b   (src_b),
      .val_a   (bus.valA),
      .val_b   (bus.valB),
      .we_e    (commit),
      .dst_e   (dst_e),
      .wdata_e (bus.valE),
      .we_m    (commit),
      .dst_m   (dst_m),
      .wdata_m (bus.valM)
   );

   assign bus.stat    = stat_q;
   assign bus.halted  = (stat_q != AOK);
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Randomized scoreboard bench for decode_writeback against an
// architectural Y86-64 register/status model.
module tb_decode_writeback;
   import y86_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_writeback_if #(.CNT_W(8)) bus ();

   decode_writeback #(
      .RSP_RESET (64'd1000),
      .CNT_W     (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  st;
      logic        h;
      logic [7:0]  r;
   } exp_t;

   exp_t        q[$];
   logic [63:0] m_reg [16];
   logic [2:0]  m_stat;
   logic [7:0]  m_ret;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural rules for which registers an instruction reads and writes.
   function automatic logic [3:0] f_src_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic == CMOVXX || ic == RMMOVQ || ic == OPQ || ic == PUSHQ) return ra;
      if (ic == POPQ || ic == RET) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_src_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic == OPQ || ic == RMMOVQ || ic == MRMOVQ) return rb;
      if (ic == PUSHQ || ic == POPQ || ic == CALL || ic == RET) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
      if (ic == IRMOVQ || ic == OPQ) return rb;
      if (ic == CMOVXX) return c ? rb : 4'hF;
      if (ic == PUSHQ || ic == POPQ || ic == CALL || ic == RET) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] f_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      if (ic == MRMOVQ || ic == POPQ) return ra;
      return 4'hF;
   endfunction

   function automatic logic [63:0] rd(input logic [3:0] s);
      return (s == 4'hF) ? 64'd0 : m_reg[s];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 64'd0;
      m_reg[4] = 64'd1000;
      m_stat   = 3'd1;
      m_ret    = 8'd0;
   endtask

   // Called just after a rising edge: present one instruction, queue the
   // response expected before the next edge, then advance the model.
   task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm,
                        input logic ie, input logic iv, input logic de);
      exp_t       e;
      logic [2:0] ns;
      logic [3:0] de_r;
      logic [3:0] dm_r;
      bus.icode       = ic;
      bus.ifun        = 4'($urandom);
      bus.rA          = ra;
      bus.rB          = rb;
      bus.cnd         = c;
      bus.valE        = ve;
      bus.valM        = vm;
      bus.imem_error  = ie;
      bus.instr_valid = iv;
      bus.dmem_error  = de;
      e.a  = rd(f_src_a(ic, ra));
      e.b  = rd(f_src_b(ic, rb));
      e.st = m_stat;
      e.h  = (m_stat != 3'd1);
      e.r  = m_ret;
      q.push_back(e);
      if (m_stat == 3'd1) begin
         if (ie) ns = 3'd3;
         else if (!iv) ns = 3'd4;
         else if (de) ns = 3'd3;
         else if (ic == 4'h0) ns = 3'd2;
         else ns = 3'd1;
         if (ns == 3'd1) begin
            de_r = f_dst_e(ic, rb, c);
            dm_r = f_dst_m(ic, ra);
            if (de_r != 4'hF) m_reg[de_r] = ve;
            if (dm_r != 4'hF) m_reg[dm_r] = vm;
            m_ret = m_ret + 8'd1;
         end
         m_stat = ns;
      end
      @(posedge clk);
      #1;
   endtask

   // Reset asserted between edges: state must clear with no clock edge.
   task automatic reset_pulse();
      logic [3:0] ra;
      ra              = 4'($urandom_range(0, 14));
      bus.icode       = OPQ;
      bus.rA          = ra;
      bus.rB          = 4'd4;
      bus.imem_error  = 1'b0;
      bus.instr_valid = 1'b1;
      bus.dmem_error  = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_stat", 64'(bus.stat), 64'd1);
      check("rst_halted", 64'(bus.halted), 64'd0);
      check("rst_retired", 64'(bus.retired), 64'd0);
      check("rst_valA", bus.valA, (ra == 4'd4) ? 64'd1000 : 64'd0);
      check("rst_valB", bus.valB, 64'd1000);
      rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("valA", bus.valA, e.a);
            check("valB", bus.valB, e.b);
            check("stat", 64'(bus.stat), 64'(e.st));
            check("halted", 64'(bus.halted), 64'(e.h));
            check("retired", 64'(bus.retired), 64'(e.r));
         end
      end
   end

   initial begin : driver
      logic [3:0]  ic;
      logic        ie, iv, de;
      bus.icode = 4'h1; bus.ifun = 4'h0; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
      bus.valE = '0; bus.valM = '0;
      bus.imem_error = 1'b0; bus.instr_valid = 1'b1; bus.dmem_error = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset_pulse();

      // Directed scenarios
      drive(IRMOVQ, 4'hF, 4'd2, 1'b0, 64'h55, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(OPQ,    4'd2, 4'd3, 1'b0, 64'h99, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(CMOVXX, 4'd1, 4'd5, 1'b0, 64'd7,  64'h0, 1'b0, 1'b1, 1'b0);
      drive(OPQ,    4'd5, 4'd2, 1'b0, 64'h55, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(CMOVXX, 4'd1, 4'd5, 1'b1, 64'd7,  64'h0, 1'b0, 1'b1, 1'b0);
      drive(OPQ,    4'd5, 4'd2, 1'b0, 64'h55, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(POPQ,   4'd4, 4'hF, 1'b0, 64'd1008, 64'hAB, 1'b0, 1'b1, 1'b0);
      drive(MRMOVQ, 4'd6, 4'hF, 1'b0, 64'h0, 64'd123, 1'b0, 1'b1, 1'b0);
      drive(OPQ,    4'd4, 4'd6, 1'b0, 64'h1, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(HALT,   4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(IRMOVQ, 4'hF, 4'd1, 1'b0, 64'd9, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(OPQ,    4'd1, 4'd1, 1'b0, 64'd3, 64'h0, 1'b0, 1'b1, 1'b0);
      reset_pulse();
      drive(RMMOVQ, 4'd1, 4'd2, 1'b0, 64'h10, 64'h0, 1'b0, 1'b1, 1'b1);
      drive(NOP,    4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(IRMOVQ, 4'hF, 4'd3, 1'b0, 64'd5, 64'h0, 1'b0, 1'b1, 1'b0);
      reset_pulse();
      drive(IRMOVQ, 4'hF, 4'd7, 1'b0, 64'd77, 64'h0, 1'b0, 1'b1, 1'b0);
      drive(NOP,    4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
      drive(OPQ,    4'd7, 4'd7, 1'b0, 64'd1, 64'h0, 1'b0, 1'b1, 1'b0);
      reset_pulse();
      drive(NOP,    4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      drive(NOP,    4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);

      // Counter wrap
      reset_pulse();
      for (int k = 0; k < 258; k++) begin
         drive(NOP, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
      end

      // Randomized traffic
      reset_pulse();
      for (int k = 0; k < 3000; k++) begin
         if ((k % 300 == 299) || (m_stat != 3'd1 && $urandom_range(0, 7) == 0)) reset_pulse();
         if ($urandom_range(0, 63) == 0) ic = 4'h0;
         else ic = 4'($urandom_range(1, 11));
         if ($urandom_range(0, 99) == 0) ic = 4'($urandom_range(12, 15));
         iv = (ic <= 4'd11) ? ($urandom_range(0, 127) != 0) : 1'b0;
         ie = ($urandom_range(0, 255) == 0);
         de = ($urandom_range(0, 255) == 0);
         drive(ic, 4'($urandom), 4'($urandom), 1'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, ie, iv, de);
      end

      repeat (3) @(negedge clk);
      check("queue_drain", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
